sm_to_bcd_conv: RTL and testbench

- Sequential consumer of the sign-magnitude add/subtract unit's results: takes one sign-magnitude word plus its overflow flag and converts it to signed BCD for the lab display path.
- Conversion is bit-serial double-dabble, one magnitude bit per clock.
- Valid/ready handshake on input and output, so results can be queued from the adder/subtractor and drained by the display driver.

---
 rtl/sm_to_bcd_conv.sv | 100 ++++++++++
 tb/tb_sm_to_bcd_conv.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_to_bcd_conv.sv
// Sign-magnitude to signed-BCD converter for the display path.
// Bit-serial double-dabble: one magnitude bit per clock, valid/ready on both sides.
module sm_to_bcd_conv #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_sm,
    input  logic                  in_ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_ovf
);
    localparam int MW = WIDTH - 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [MW-1:0]  mag_sr;
    logic [BW-1:0]  bcd_sr, bcd_adj, bcd_shf;
    logic [CW-1:0]  cnt;
    logic           sign_q, nz_q, ovf_q;
    logic           last_shift;

    // Add-3 correction on every digit before the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign bcd_adj[4*d +: 4] = (bcd_sr[4*d +: 4] >= 4'd5) ? bcd_sr[4*d +: 4] + 4'd3
                                                              : bcd_sr[4*d +: 4];
    end

    assign bcd_shf    = {bcd_adj[BW-2:0], mag_sr[MW-1]};
    assign last_shift = (state == SHIFT) && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            nz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mag_sr <= in_sm[MW-1:0];
            bcd_sr <= '0;
            cnt    <= CW'(WIDTH - 1);
            sign_q <= in_sm[WIDTH-1];
            nz_q   <= |in_sm[MW-1:0];
            ovf_q  <= in_ovf;
        end else if (state == SHIFT) begin
            mag_sr <= {mag_sr[MW-2:0], 1'b0};
            bcd_sr <= bcd_shf;
            cnt    <= cnt - CW'(1);
        end
    end

    // Result registers only move on entry to DONE; out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bcd <= '0;
            out_neg <= 1'b0;
            out_ovf <= 1'b0;
        end else if (last_shift) begin
            out_bcd <= ovf_q ? {BW{1'b1}} : bcd_shf;
            out_neg <= ~ovf_q & sign_q & nz_q;
            out_ovf <= ovf_q;
        end
    end
endmodule

// File: tb/tb_sm_to_bcd_conv.sv
// Bench for sm_to_bcd_conv: directed literal cases plus randomized words against a
// transaction-level model (decimal conversion by repeated division).
module tb_sm_to_bcd_conv;
    localparam int W  = 17;
    localparam int D  = 5;
    localparam int BW = 4 * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_sm = '0;
    logic          in_ovf = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_bcd;
    logic          out_neg;
    logic          out_ovf;

    int  checks = 0;
    int  errors = 0;
    bit  rand_mode = 0;

    sm_to_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sm(in_sm), .in_ovf(in_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_neg(out_neg), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] ref_bcd(input logic [W-1:0] sm, input logic ovf);
        logic [BW-1:0] r;
        int m;
        r = '0;
        if (ovf) return {BW{1'b1}};
        m = int'(sm[W-2:0]);
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Transaction model: a word is taken when idle, its result appears WIDTH-1
    // edges after the accepting edge, and leaves on out_ready.
    bit            m_busy, m_valid;
    int            m_cnt;
    logic [BW-1:0] m_bcd, p_bcd;
    logic          m_neg, m_ovf, p_neg, p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_valid <= 0; m_cnt <= 0;
            m_bcd <= '0; m_neg <= 0; m_ovf <= 0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 0; m_valid <= 1;
                m_bcd <= p_bcd; m_neg <= p_neg; m_ovf <= p_ovf;
            end else m_cnt <= m_cnt - 1;
        end else if (in_valid) begin
            m_busy <= 1;
            m_cnt  <= W - 1;
            p_bcd  <= ref_bcd(in_sm, in_ovf);
            p_neg  <= !in_ovf && in_sm[W-1] && (in_sm[W-2:0] != 0);
            p_ovf  <= in_ovf;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_bcd", 32'(out_bcd), 32'(m_bcd));
                chk("model_neg", 32'(out_neg), 32'(m_neg));
                chk("model_ovf", 32'(out_ovf), 32'(m_ovf));
            end
        end
    end

    always @(negedge clk) if (rand_mode) out_ready <= ($urandom % 4) != 0;

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic push(input logic [W-1:0] sm, input logic ovf, output bit ok);
        ok = 0;
        in_sm = sm; in_ovf = ovf; in_valid = 1;
        for (int k = 0; k < 300; k++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 0;
        in_sm = W'($urandom);
        in_ovf = 1'($urandom);
        if (!ok) chk("accept_timeout", 32'(ok), 32'(1));
    endtask

    // Counts negedges from the one after the accepting edge until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_word(input string name, input logic [W-1:0] sm, input logic ovf,
                            input logic [BW-1:0] eb, input logic en, input logic eo);
        bit ok;
        int lat;
        push(sm, ovf, ok);
        wait_valid(lat);
        // The handshake cycle is counted as the first of the WIDTH cycles.
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_bcd"}, 32'(out_bcd), 32'(eb));
        chk({name, "_neg"}, 32'(out_neg), 32'(en));
        chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    endtask

    initial begin
        bit ok;
        int lat;
        logic [W-1:0] sm;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_bcd", 32'(out_bcd), 32'(0));
        chk("rst_out_neg", 32'(out_neg), 32'(0));
        chk("rst_out_ovf", 32'(out_ovf), 32'(0));

        run_word("pos136", 17'b0_0000000010001000, 1'b0, 20'h00136, 1'b0, 1'b0);
        run_word("neg65534", 17'b1_1111111111111110, 1'b0, 20'h65534, 1'b1, 1'b0);
        run_word("negzero", 17'b1_0000000000000000, 1'b0, 20'h00000, 1'b0, 1'b0);
        run_word("ovf", 17'b0_0000000100000001, 1'b1, 20'hFFFFF, 1'b0, 1'b1);
        run_word("max", 17'b0_1111111111111111, 1'b0, 20'h65535, 1'b0, 1'b0);

        // Back-pressure with a competing word presented in DONE.
        @(negedge clk);
        out_ready = 0;
        push(17'd4242, 1'b0, ok);
        wait_valid(lat);
        in_valid = 1; in_sm = {1'b1, 16'd777}; in_ovf = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_bcd", 32'(out_bcd), 32'h04242);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'(0));
        chk("bp_release_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 0;
        wait_valid(lat);
        chk("bp_new_latency", 32'(lat), 32'(W));
        chk("bp_new_bcd", 32'(out_bcd), 32'h00777);
        chk("bp_new_neg", 32'(out_neg), 32'(1));

        // Reset abort at SHIFT cycle 8.
        @(negedge clk);
        push({1'b1, 16'd129}, 1'b0, ok);
        repeat (7) @(negedge clk);
        #2 rst_n = 0;
        #1 chk("abort_shift_valid", 32'(out_valid), 32'(0));
        chk("abort_shift_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("abort_idle_ready", 32'(in_ready), 32'(1));
        run_word("reissue129", {1'b1, 16'd129}, 1'b0, 20'h00129, 1'b1, 1'b0);

        // Reset abort while holding a result in DONE.
        @(negedge clk);
        out_ready = 0;
        push(17'd31337, 1'b0, ok);
        wait_valid(lat);
        chk("abort_done_pre", 32'(out_valid), 32'(1));
        #2 rst_n = 0;
        #1 chk("abort_done_valid", 32'(out_valid), 32'(0));
        chk("abort_done_bcd", 32'(out_bcd), 32'(0));
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        @(negedge clk);

        // Randomized words checked by the model.
        rand_mode = 1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom % 8)
                0: sm = '0;
                1: sm = {1'b1, 16'd0};
                2: sm = '1;
                default: sm = W'($urandom);
            endcase
            repeat ($urandom % 3) @(negedge clk);
            push(sm, ($urandom % 6) == 0, ok);
        end
        rand_mode = 0;
        @(negedge clk);
        out_ready = 1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
